// File: rtl/accum_sequencer_pkg.sv
// accum_sequencer shared types and constants
// state encoding, flush length and default widths
package accum_sequencer_pkg;

  localparam int CNT_W_DEF        = 32;
  localparam int SUM_W_DEF        = 64;
  localparam int FLUSH_CYCLES     = 3;
  localparam int BEATS_PER_RESULT = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GATE  = 3'd1,
    S_FLUSH = 3'd2,
    S_SEND0 = 3'd3,
    S_SEND1 = 3'd4
  } state_t;

endpackage

// File: rtl/accum_result_tx.sv
// accum_result_tx: holds a captured sum/count
// and ships it as a two-beat AXI-Stream packet
module accum_result_tx
  import accum_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             capture,
  input  logic [SUM_W-1:0] acc_value,
  input  logic [CNT_W-1:0] acc_count,
  output logic [SUM_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             done
);

  state_t           st;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hs;

  assign hs   = m_tvalid & m_tready;
  assign done = hs & m_tlast;

  // data is a pure function of held registers, so it
  // cannot move while a beat is stalled
  assign m_tdata = m_tlast ? SUM_W'(cnt_q) : sum_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      st       <= S_IDLE;
      sum_q    <= '0;
      cnt_q    <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (capture) begin
            sum_q    <= acc_value;
            cnt_q    <= acc_count;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            st       <= S_SEND0;
          end
        end
        S_SEND0: begin
          if (hs) begin
            m_tlast <= 1'b1;
            st      <= S_SEND1;
          end
        end
        S_SEND1: begin
          if (hs) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            st       <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/accum_sequencer.sv
// accum_sequencer: gates one accumulator window,
// waits out the drain and sends sum/count downstream
module accum_sequencer
  import accum_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] window_len,
  output logic             busy,
  output logic             acc_enable,
  input  logic [SUM_W-1:0] acc_value,
  input  logic [CNT_W-1:0] acc_count,
  output logic [SUM_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             count_err
);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] down_q;
  logic [1:0]       flush_q;
  logic             capture;
  logic             tx_done;
  logic [CNT_W:0]   exp_cnt;

  // one extra bit so an all-ones length does not wrap
  assign exp_cnt = {1'b0, len_q} + (CNT_W+1)'(1);

  // the drained result is only valid on this one edge
  assign capture = (state == S_FLUSH) &&
                   (flush_q == 2'(FLUSH_CYCLES - 1));

  always_ff @(posedge aclk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      down_q     <= '0;
      flush_q    <= '0;
      acc_enable <= 1'b0;
      busy       <= 1'b0;
      count_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && window_len != '0) begin
            len_q      <= window_len;
            down_q     <= window_len;
            acc_enable <= 1'b1;
            busy       <= 1'b1;
            count_err  <= 1'b0;
            state      <= S_GATE;
          end
        end
        S_GATE: begin
          if (down_q == CNT_W'(1)) begin
            acc_enable <= 1'b0;
            flush_q    <= '0;
            state      <= S_FLUSH;
          end else begin
            down_q <= down_q - CNT_W'(1);
          end
        end
        S_FLUSH: begin
          if (capture) begin
            count_err <= ({1'b0, acc_count} != exp_cnt);
            state     <= S_SEND0;
          end else begin
            flush_q <= flush_q + 2'd1;
          end
        end
        S_SEND0: begin
          if (m_tvalid && m_tready) state <= S_SEND1;
        end
        S_SEND1: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  accum_result_tx #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_tx (
    .aclk      (aclk),
    .rst       (rst),
    .capture   (capture),
    .acc_value (acc_value),
    .acc_count (acc_count),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: drives windows against a stub
// accumulator and checks packets against expected arithmetic
module tb_accum_sequencer;

  logic        aclk;
  logic        rst;
  logic        start;
  logic [31:0] window_len;
  logic        busy;
  logic        acc_enable;
  logic [63:0] acc_value;
  logic [31:0] acc_count;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        count_err;

  int checks = 0;
  int errors = 0;

  accum_sequencer dut (
    .aclk       (aclk),
    .rst        (rst),
    .start      (start),
    .window_len (window_len),
    .busy       (busy),
    .acc_enable (acc_enable),
    .acc_value  (acc_value),
    .acc_count  (acc_count),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .count_err  (count_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // stub accumulator: one sample per enabled cycle plus
  // one on the falling edge; result shown for one cycle
  longint      acc_in = 0;
  bit          force_bad = 0;
  int          nsamp = 0;
  int          drain = 0;
  bit          prev_en = 0;
  bit          show;
  logic [31:0] res_cnt;
  logic [63:0] res_sum;

  always @(negedge aclk) begin
    show = 0;
    if (drain > 0) begin
      drain--;
      show = (drain == 0);
    end
    if (acc_enable === 1'b1) nsamp++;
    else if (prev_en) begin
      res_cnt = 32'(nsamp + 1);
      res_sum = 64'(longint'(res_cnt) * acc_in);
      drain   = 2;
      nsamp   = 0;
    end
    prev_en = (acc_enable === 1'b1);
    if (show) begin
      acc_value = res_sum;
      acc_count = force_bad ? 32'd3 : res_cnt;
    end else begin
      acc_value = {$urandom, $urandom};
      acc_count = $urandom | 32'h8000_0000;
    end
  end

  task automatic run_window(input int L, input longint val,
                            input int stall, input bit rnd,
                            input bit bad, input int junk0,
                            input int junk1);
    int en_n = 0, first_en = -1, first_v = -1;
    int hs = 0, hs2_k = -1, extra = 0;
    bit done = 0, stable = 1, pend = 0;
    logic [63:0] pd, b0, b1, exp_sum;
    logic pl, l0, l1;
    b0 = 'x; b1 = 'x; l0 = 'x; l1 = 'x;
    exp_sum = 64'(longint'(L + 1) * val);
    acc_in = val;
    force_bad = bad;
    start = 1'b1;
    window_len = 32'(L);
    m_tready = 1'b1;
    for (int k = 0; k < L + 60 && !done; k++) begin
      @(negedge aclk);
      if (k == 0) chk("idle_busy", 64'(busy), 0);
      if (k == 1) begin
        chk("busy_up", 64'(busy), 1);
        chk("err_clr", 64'(count_err), 0);
      end
      if (acc_enable) begin
        en_n++;
        if (first_en < 0) first_en = k;
      end
      if (m_tvalid && first_v < 0) first_v = k;
      if (pend && m_tvalid &&
          (m_tdata !== pd || m_tlast !== pl)) stable = 0;
      pend = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      if (m_tvalid && m_tready) begin
        if (hs == 0) begin
          b0 = m_tdata;
          l0 = m_tlast;
        end else if (hs == 1) begin
          b1 = m_tdata;
          l1 = m_tlast;
          hs2_k = k;
        end
        hs++;
      end
      if (hs2_k >= 0 && k == hs2_k + 1) begin
        chk("busy_fall", 64'(busy), 0);
        done = 1;
      end
      @(posedge aclk);
      #1;
      start = (k + 1 == junk0) || (k + 1 == junk1);
      if (start) window_len = 32'd7;
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      else m_tready = !((k + 1) >= L + 4 &&
                        (k + 1) < L + 4 + stall);
    end
    chk("done", 64'(done), 1);
    start = 1'b0;
    m_tready = 1'b1;
    for (int j = 0; j < L + 10; j++) begin
      @(negedge aclk);
      if (acc_enable) en_n++;
      if (m_tvalid) extra++;
      @(posedge aclk);
      #1;
    end
    chk("first_en", 64'(first_en), 1);
    chk("en_cycles", 64'(en_n), 64'(L));
    chk("valid_rise", 64'(first_v), 64'(L + 4));
    chk("beat0", b0, exp_sum);
    chk("last0", 64'(l0), 0);
    chk("beat1", b1, bad ? 64'd3 : 64'(L + 1));
    chk("last1", 64'(l1), 1);
    chk("handshakes", 64'(hs), 2);
    chk("stable", 64'(stable), 1);
    chk("no_extra", 64'(extra), 0);
    chk("count_err", 64'(count_err), 64'(bad));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    rst = 1'b1;
    start = 1'b0;
    window_len = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_enable", 64'(acc_enable), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(m_tvalid), 0);
    chk("rst_last", 64'(m_tlast), 0);
    chk("rst_err", 64'(count_err), 0);
    chk("rst_data", m_tdata, 0);
    @(posedge aclk);
    #1;
    rst = 1'b0;

    run_window(4, 5, 0, 0, 0, -1, -1);
    run_window(3, -7, 0, 0, 0, -1, -1);
    run_window(5, 1234, 10, 0, 0, -1, -1);

    // zero-length start must be ignored
    start = 1'b1;
    window_len = '0;
    @(posedge aclk);
    #1;
    start = 1'b0;
    act = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge aclk);
      if (acc_enable || busy) act++;
      @(posedge aclk);
      #1;
    end
    chk("len0_ignored", 64'(act), 0);

    run_window(4, 9, 0, 0, 0, 2, 8);
    run_window(4, 5, 0, 0, 1, -1, -1);
    run_window(3, 2, 0, 0, 0, -1, -1);

    // reset in the third cycle of a 10-cycle window
    start = 1'b1;
    window_len = 32'd10;
    acc_in = 3;
    force_bad = 0;
    @(posedge aclk);
    #1;
    start = 1'b0;
    @(posedge aclk);
    #1;
    rst = 1'b1;
    @(posedge aclk);
    #1;
    rst = 1'b0;
    @(negedge aclk);
    chk("rst_mid_en", 64'(acc_enable), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    act = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge aclk);
      if (m_tvalid) act++;
      @(posedge aclk);
      #1;
    end
    chk("rst_no_valid", 64'(act), 0);
    run_window(2, 11, 0, 0, 0, -1, -1);

    for (int r = 0; r < 8; r++) begin
      run_window(int'($urandom_range(1, 12)),
                 longint'($urandom_range(0, 2000)) - 1000,
                 0, 1, 0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
